// File: rtl/gdp_pkg.sv
// Shared types for the GDP scheduler: the 16-bit signed operand type, the FSM state
// encoding and the most-negative score used to seed the best tracker.
package gdp_pkg;

  typedef logic signed [15:0] num;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam num NUM_MIN = 16'sh8000;

endpackage

// File: rtl/gdp_scheduler_if.sv
// Bus bundle of the GDP scheduler: feature input, stats memory port, GDP datapath port
// and score/status outputs. master = scheduler side, slave = surrounding environment.
interface gdp_scheduler_if
  import gdp_pkg::*;
#(
  parameter int unsigned N_COMPONENTS = 25,
  parameter int unsigned ADDR_W       = 13
);

  logic [16*N_COMPONENTS-1:0] x;
  logic                       x_valid;
  logic                       stats_rd;
  logic [ADDR_W-1:0]          stats_addr;
  num                         stats_mean;
  num                         stats_omega;
  num                         stats_k;
  logic                       gdp_en;
  logic                       gdp_first;
  logic                       gdp_last;
  num                         gdp_x;
  num                         gdp_mean;
  num                         gdp_omega;
  num                         gdp_k;
  num                         gdp_score;
  logic                       gdp_score_valid;
  logic [7:0]                 score_index;
  num                         score;
  logic                       score_valid;
  logic [7:0]                 best_index;
  num                         best_score;
  logic                       busy;
  logic                       done;
  logic                       overrun;

  modport master (
    input  x, x_valid, stats_mean, stats_omega, stats_k, gdp_score, gdp_score_valid,
    output stats_rd, stats_addr, gdp_en, gdp_first, gdp_last, gdp_x, gdp_mean, gdp_omega,
           gdp_k, score_index, score, score_valid, best_index, best_score, busy, done, overrun
  );

  modport slave (
    output x, x_valid, stats_mean, stats_omega, stats_k, gdp_score, gdp_score_valid,
    input  stats_rd, stats_addr, gdp_en, gdp_first, gdp_last, gdp_x, gdp_mean, gdp_omega,
           gdp_k, score_index, score, score_valid, best_index, best_score, busy, done, overrun
  );

endinterface

// File: rtl/gdp_best_tracker.sv
// Running signed maximum with index; ties keep the earlier index.
// Compiled in only when GDP_SCHED_BEST_EN is defined, otherwise outputs are constant 0.
module gdp_best_tracker
  import gdp_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       upd,
  input  num         score_in,
  input  logic [7:0] index_in,
  output num         best_score,
  output logic [7:0] best_index
);

`ifdef GDP_SCHED_BEST_EN
  num         best_score_q, best_score_d;
  logic [7:0] best_index_q, best_index_d;

  always_comb begin
    best_score_d = best_score_q;
    best_index_d = best_index_q;
    if (clr) begin
      best_score_d = NUM_MIN;
      best_index_d = '0;
    end else if (upd && (score_in > best_score_q)) begin
      best_score_d = score_in;
      best_index_d = index_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      best_score_q <= NUM_MIN;
      best_index_q <= '0;
    end else begin
      best_score_q <= best_score_d;
      best_index_q <= best_index_d;
    end
  end

  assign best_score = best_score_q;
  assign best_index = best_index_q;
`else
  logic unused_inputs;
  assign unused_inputs = ^{clk, reset, clr, upd, score_in, index_in};
  assign best_score    = '0;
  assign best_index    = '0;
`endif

endmodule

// File: rtl/gdp_scheduler.sv
// Walks every (senone, component) pair through one shared GDP pipeline per observation
// and forwards per-senone scores. Best tracking is enabled by GDP_SCHED_BEST_EN.
module gdp_scheduler
  import gdp_pkg::*;
#(
  parameter int unsigned N_COMPONENTS = 25,
  parameter int unsigned N_SENONES    = 256,
  parameter int unsigned STATS_LAT    = 2,
  parameter int unsigned ADDR_W       = 13
)(
  input logic              clk,
  input logic              reset,
  gdp_scheduler_if.master  bus
);

  localparam int unsigned C_W  = $clog2(N_COMPONENTS);
  localparam int unsigned S_W  = (N_SENONES > 1) ? $clog2(N_SENONES) : 1;
  localparam int unsigned RX_W = $clog2(N_SENONES + 1);
  localparam int unsigned X_W  = 16 * N_COMPONENTS;

  state_e            state_q, state_d;
  logic [X_W-1:0]    x_q, x_d;
  logic [C_W-1:0]    c_q, c_d;
  logic [S_W-1:0]    s_q, s_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_q, rd_d;
  logic              pv_q [STATS_LAT];
  logic              pv_d [STATS_LAT];
  logic [C_W-1:0]    pc_q [STATS_LAT];
  logic [C_W-1:0]    pc_d [STATS_LAT];
  logic              en_q, en_d, first_q, first_d, last_q, last_d;
  num                gx_q, gx_d, gmean_q, gmean_d, gomega_q, gomega_d, gk_q, gk_d;
  logic [RX_W-1:0]   rx_q, rx_d;
  logic              sv_q, sv_d;
  num                score_q, score_d;
  logic [7:0]        sidx_q, sidx_d;
  logic              busy_q, busy_d, done_q, done_d, ovr_q, ovr_d;
  logic              start, accept;
  num                best_score;
  logic [7:0]        best_index;

  // Issue sequencing, receive counting and status.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    c_d     = c_q;
    s_d     = s_q;
    addr_d  = addr_q;
    rd_d    = rd_q;
    rx_d    = rx_q;
    done_d  = 1'b0;
    ovr_d   = ovr_q;
    start   = 1'b0;
    accept  = bus.gdp_score_valid && ((state_q == ST_ISSUE) || (state_q == ST_DRAIN));
    if (accept) rx_d = rx_q + RX_W'(1);
    unique case (state_q)
      ST_IDLE: if (bus.x_valid) begin
        start   = 1'b1;
        state_d = ST_ISSUE;
        x_d     = bus.x;
        c_d     = '0;
        s_d     = '0;
        addr_d  = '0;
        rd_d    = 1'b1;
        rx_d    = '0;
        ovr_d   = 1'b0;
      end
      ST_ISSUE: begin
        addr_d = addr_q + ADDR_W'(1);
        if (c_q == C_W'(N_COMPONENTS - 1)) begin
          c_d = '0;
          s_d = s_q + S_W'(1);
          if (s_q == S_W'(N_SENONES - 1)) begin
            rd_d    = 1'b0;
            state_d = ST_DRAIN;
          end
        end else begin
          c_d = c_q + C_W'(1);
        end
      end
      ST_DRAIN: if (rx_q == RX_W'(N_SENONES)) begin
        state_d = ST_DONE;
        done_d  = 1'b1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (bus.x_valid && (state_q != ST_IDLE)) ovr_d = 1'b1;
    busy_d = (state_d != ST_IDLE);
  end

  // Component index travels with each read so returning data finds its x[c].
  always_comb begin
    pv_d[0] = rd_q;
    pc_d[0] = c_q;
    for (int i = 1; i < STATS_LAT; i++) begin
      pv_d[i] = pv_q[i-1];
      pc_d[i] = pc_q[i-1];
    end
  end

  always_comb begin
    en_d     = pv_q[STATS_LAT-1];
    first_d  = en_d && (pc_q[STATS_LAT-1] == '0);
    last_d   = en_d && (pc_q[STATS_LAT-1] == C_W'(N_COMPONENTS - 1));
    gx_d     = gx_q;
    gmean_d  = gmean_q;
    gomega_d = gomega_q;
    gk_d     = gk_q;
    if (en_d) begin
      gx_d     = num'(x_q[16*int'(pc_q[STATS_LAT-1]) +: 16]);
      gmean_d  = bus.stats_mean;
      gomega_d = bus.stats_omega;
      gk_d     = bus.stats_k;
    end
    sv_d    = accept;
    score_d = accept ? bus.gdp_score : score_q;
    sidx_d  = accept ? 8'(rx_q) : sidx_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      x_q      <= '0;
      c_q      <= '0;
      s_q      <= '0;
      addr_q   <= '0;
      rd_q     <= 1'b0;
      for (int i = 0; i < STATS_LAT; i++) begin
        pv_q[i] <= 1'b0;
        pc_q[i] <= '0;
      end
      en_q     <= 1'b0;
      first_q  <= 1'b0;
      last_q   <= 1'b0;
      gx_q     <= '0;
      gmean_q  <= '0;
      gomega_q <= '0;
      gk_q     <= '0;
      rx_q     <= '0;
      sv_q     <= 1'b0;
      score_q  <= '0;
      sidx_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      c_q      <= c_d;
      s_q      <= s_d;
      addr_q   <= addr_d;
      rd_q     <= rd_d;
      for (int i = 0; i < STATS_LAT; i++) begin
        pv_q[i] <= pv_d[i];
        pc_q[i] <= pc_d[i];
      end
      en_q     <= en_d;
      first_q  <= first_d;
      last_q   <= last_d;
      gx_q     <= gx_d;
      gmean_q  <= gmean_d;
      gomega_q <= gomega_d;
      gk_q     <= gk_d;
      rx_q     <= rx_d;
      sv_q     <= sv_d;
      score_q  <= score_d;
      sidx_q   <= sidx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ovr_q    <= ovr_d;
    end
  end

  gdp_best_tracker u_best (
    .clk        (clk),
    .reset      (reset),
    .clr        (start),
    .upd        (accept),
    .score_in   (bus.gdp_score),
    .index_in   (8'(rx_q)),
    .best_score (best_score),
    .best_index (best_index)
  );

  assign bus.stats_rd    = rd_q;
  assign bus.stats_addr  = addr_q;
  assign bus.gdp_en      = en_q;
  assign bus.gdp_first   = first_q;
  assign bus.gdp_last    = last_q;
  assign bus.gdp_x       = gx_q;
  assign bus.gdp_mean    = gmean_q;
  assign bus.gdp_omega   = gomega_q;
  assign bus.gdp_k       = gk_q;
  assign bus.score_index = sidx_q;
  assign bus.score       = score_q;
  assign bus.score_valid = sv_q;
  assign bus.best_index  = best_index;
  assign bus.best_score  = best_score;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.overrun     = ovr_q;

endmodule

// File: tb/tb_gdp_scheduler.sv
// Scoreboard bench for gdp_scheduler: stats memory and GDP models drive the DUT,
// expectations are queued at stimulus time and popped by a negedge monitor.
module tb_gdp_scheduler;
  import gdp_pkg::*;

  localparam int NC = 3, NS = 4, LAT = 2, AW = 4, NB = NC * NS;
`ifdef GDP_SCHED_BEST_EN
  localparam bit BEST_EN = 1'b1;
`else
  localparam bit BEST_EN = 1'b0;
`endif

  typedef struct { int cyc; int addr; } addr_t;
  typedef struct { int cyc; int first; int last; int x; int mean; int omega; int k; } beat_t;
  typedef struct { int cyc; int idx; int score; int bidx; int bscore; } score_t;

  logic clk, reset;
  int cyc = 0;
  int checks = 0, errors = 0;

  addr_t  addr_q[$];
  beat_t  beat_q[$];
  score_t score_q[$];
  int     done_q[$];
  int     ret_q[$];
  int mem_mean[NB], mem_omega[NB], mem_k[NB];
  int xv[NC];
  int plan[NS];
  int sen_cnt, rx_model, bm_score, bm_idx, done_cnt;
  bit ret_en;
  int mp_v[LAT+1], mp_a[LAT+1];

  gdp_scheduler_if #(.N_COMPONENTS(NC), .ADDR_W(AW)) bus ();

  gdp_scheduler #(.N_COMPONENTS(NC), .N_SENONES(NS), .STATS_LAT(LAT), .ADDR_W(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int rnd16();
    logic signed [15:0] v;
    v = 16'($urandom);
    return int'(v);
  endfunction

  // Fixed-latency stats memory: data for a read in cycle k is presented during cycle k+LAT.
  always @(negedge clk) begin
    for (int i = LAT; i > 0; i--) begin
      mp_v[i] = mp_v[i-1];
      mp_a[i] = mp_a[i-1];
    end
    mp_v[0] = int'(bus.stats_rd);
    mp_a[0] = int'(bus.stats_addr);
    if (mp_v[LAT] != 0) begin
      bus.stats_mean  = 16'(mem_mean[mp_a[LAT]]);
      bus.stats_omega = 16'(mem_omega[mp_a[LAT]]);
      bus.stats_k     = 16'(mem_k[mp_a[LAT]]);
    end else begin
      bus.stats_mean  = 16'($urandom);
      bus.stats_omega = 16'($urandom);
      bus.stats_k     = 16'($urandom);
    end
  end

  // GDP model: one planned score per completed senone, returned in order after a random delay.
  always @(negedge clk) begin : gdp_model
    int sc;
    score_t e;
    if (ret_en) begin
      if (bus.gdp_en && bus.gdp_last && sen_cnt < NS) begin
        ret_q.push_back(plan[sen_cnt]);
        sen_cnt++;
      end
      bus.gdp_score_valid = 1'b0;
      bus.gdp_score       = 16'($urandom);
      if (ret_q.size() > 0 && $urandom_range(0, 3) != 0) begin
        sc = ret_q.pop_front();
        bus.gdp_score_valid = 1'b1;
        bus.gdp_score       = 16'(sc);
        if (sc > bm_score) begin
          bm_score = sc;
          bm_idx   = rx_model;
        end
        e.cyc    = cyc + 1;
        e.idx    = rx_model;
        e.score  = sc;
        e.bidx   = BEST_EN ? bm_idx : 0;
        e.bscore = BEST_EN ? bm_score : 0;
        score_q.push_back(e);
        rx_model++;
        if (rx_model == NS) done_q.push_back(cyc + 2);
      end
    end
  end

  // Monitor: pops the expected queues whenever the DUT presents an output event.
  always @(negedge clk) begin : monitor
    addr_t  a;
    beat_t  b;
    score_t s;
    if (bus.stats_rd) begin
      if (addr_q.size() == 0) chk("addr_unexpected", 1, 0);
      else begin
        a = addr_q.pop_front();
        chk("addr_cycle", cyc, a.cyc);
        chk("stats_addr", int'(bus.stats_addr), a.addr);
      end
    end
    if (bus.gdp_en) begin
      if (beat_q.size() == 0) chk("beat_unexpected", 1, 0);
      else begin
        b = beat_q.pop_front();
        chk("beat_cycle", cyc, b.cyc);
        chk("gdp_first", int'(bus.gdp_first), b.first);
        chk("gdp_last", int'(bus.gdp_last), b.last);
        chk("gdp_x", int'(bus.gdp_x), b.x);
        chk("gdp_mean", int'(bus.gdp_mean), b.mean);
        chk("gdp_omega", int'(bus.gdp_omega), b.omega);
        chk("gdp_k", int'(bus.gdp_k), b.k);
      end
    end
    if (bus.score_valid) begin
      if (score_q.size() == 0) chk("score_unexpected", 1, 0);
      else begin
        s = score_q.pop_front();
        chk("score_cycle", cyc, s.cyc);
        chk("score_index", int'(bus.score_index), s.idx);
        chk("score", int'(bus.score), s.score);
        chk("best_index", int'(bus.best_index), s.bidx);
        chk("best_score", int'(bus.best_score), s.bscore);
      end
    end
    if (bus.done) begin
      done_cnt++;
      if (done_q.size() == 0) chk("done_unexpected", 1, 0);
      else chk("done_cycle", cyc, done_q.pop_front());
    end
  end

  task automatic start_run();
    @(posedge clk); #1;
    sen_cnt  = 0;
    rx_model = 0;
    bm_score = -32768;
    bm_idx   = 0;
    ret_q.delete();
    for (int c = 0; c < NC; c++) begin
      xv[c] = rnd16();
      bus.x[16*c +: 16] = 16'(xv[c]);
    end
    bus.x_valid = 1'b1;
    for (int i = 0; i < NB; i++) begin
      addr_q.push_back('{cyc + 1 + i, i});
      beat_q.push_back('{cyc + 2 + LAT + i, int'(i % NC == 0), int'(i % NC == NC - 1),
                         xv[i % NC], mem_mean[i], mem_omega[i], mem_k[i]});
    end
    @(posedge clk); #1;
    bus.x_valid = 1'b0;
    bus.x = '1;
  endtask

  task automatic wait_done(input string name);
    int d0 = done_cnt;
    int n  = 0;
    while (done_cnt == d0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt == d0) chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic random_plan();
    for (int s = 0; s < NS; s++)
      plan[s] = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 6)) - 3 : rnd16();
  endtask

  initial begin
    int n;
    bus.x = '0;
    bus.x_valid = 1'b0;
    bus.stats_mean = '0;
    bus.stats_omega = '0;
    bus.stats_k = '0;
    bus.gdp_score = '0;
    bus.gdp_score_valid = 1'b0;
    ret_en = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < NB; i++) begin
      mem_mean[i]  = rnd16();
      mem_omega[i] = rnd16();
      mem_k[i]     = rnd16();
    end
    reset = 1'b1;
    #3 reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_stats_rd", int'(bus.stats_rd), 0);
    chk("rst_stats_addr", int'(bus.stats_addr), 0);
    chk("rst_gdp_en", int'(bus.gdp_en), 0);
    chk("rst_gdp_x", int'(bus.gdp_x), 0);
    chk("rst_score_valid", int'(bus.score_valid), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_overrun", int'(bus.overrun), 0);
    chk("rst_best_index", int'(bus.best_index), 0);
    chk("rst_best_score", int'(bus.best_score), BEST_EN ? -32768 : 0);
    @(posedge clk); #1 reset = 1'b1;

    // Directed scores with a tie.
    plan = '{-5, 7, 7, -100};
    start_run();
    @(negedge clk);
    chk("busy_after_start", int'(bus.busy), 1);
    wait_done("run_a");
    @(negedge clk);
    chk("a_best_index", int'(bus.best_index), BEST_EN ? 1 : 0);
    chk("a_best_score", int'(bus.best_score), BEST_EN ? 7 : 0);
    chk("a_busy_idle", int'(bus.busy), 0);
    chk("a_done_pulse", int'(bus.done), 0);

    // All scores at the most negative value.
    plan = '{-32768, -32768, -32768, -32768};
    start_run();
    wait_done("run_b");
    @(negedge clk);
    chk("b_best_index", int'(bus.best_index), 0);
    chk("b_best_score", int'(bus.best_score), BEST_EN ? -32768 : 0);

    // Overrun: second x_valid mid-ISSUE must not disturb the run.
    random_plan();
    start_run();
    repeat (4) @(posedge clk);
    #1;
    bus.x = '0;
    bus.x_valid = 1'b1;
    @(posedge clk); #1;
    bus.x_valid = 1'b0;
    @(negedge clk);
    chk("overrun_set", int'(bus.overrun), 1);
    wait_done("run_c");
    @(negedge clk);
    chk("overrun_sticky", int'(bus.overrun), 1);
    random_plan();
    start_run();
    @(negedge clk);
    chk("overrun_cleared", int'(bus.overrun), 0);
    wait_done("run_d");

    // Reset during DRAIN, then a late score must be dropped.
    ret_en = 1'b0;
    random_plan();
    start_run();
    n = 0;
    while (beat_q.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (beat_q.size() > 0) chk("drain_wait_timeout", 0, 1);
    @(negedge clk);
    chk("drain_busy", int'(bus.busy), 1);
    @(posedge clk); #1 reset = 1'b0;
    #1;
    chk("mid_rst_busy", int'(bus.busy), 0);
    chk("mid_rst_best_score", int'(bus.best_score), BEST_EN ? -32768 : 0);
    @(posedge clk); #1;
    reset = 1'b1;
    bus.gdp_score = 16'sd123;
    bus.gdp_score_valid = 1'b1;
    @(posedge clk); #1;
    bus.gdp_score_valid = 1'b0;
    @(negedge clk);
    chk("late_score_dropped", int'(bus.score_valid), 0);
    chk("late_busy", int'(bus.busy), 0);
    ret_en = 1'b1;

    // Randomized runs.
    for (int r = 0; r < 4; r++) begin
      random_plan();
      start_run();
      wait_done("run_rand");
    end

    repeat (5) @(negedge clk);
    chk("addr_q_empty", addr_q.size(), 0);
    chk("beat_q_empty", beat_q.size(), 0);
    chk("score_q_empty", score_q.size(), 0);
    chk("done_q_empty", done_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gdp_scheduler.md
# gdp_scheduler

Sequences one shared Gaussian-distribution-probability (GDP) pipeline across every senone of the acoustic model for each new observation vector. It latches the vector and walks all (senone, component) pairs, reading mean/omega/k from a fixed-latency stats memory. It drives the GDP one component per cycle with first/last framing, collects the per-senone scores, and reports the best-scoring senone. It sits between the feature front end, the stats ROM and the `gdp` datapath.

## Interface
- `N_COMPONENTS`, 25: vector components per senone (≥2).
- `N_SENONES`, 256: senones scored per vector (≤256).
- `STATS_LAT`, 2: stats memory read latency in cycles (≥1).
- `ADDR_W`, 13: stats address width; must hold N_SENONES*N_COMPONENTS-1.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `x`  in  16×N_COMPONENTS  signed observation vector (`num`).
- `x_valid`  in  1  single-cycle pulse; `x` is new and valid.
- `stats_rd`  out  1  stats read strobe.
- `stats_addr`  out  ADDR_W  read address = senone*N_COMPONENTS + component.
- `stats_mean`, `stats_omega`, `stats_k`  in  16 each  read data, valid exactly STATS_LAT cycles after `stats_rd`.
- `gdp_en`  out  1  GDP input beat valid.
- `gdp_first`, `gdp_last`  out  1  beat is component 0 / component N_COMPONENTS-1.
- `gdp_x`, `gdp_mean`, `gdp_omega`, `gdp_k`  out  16  GDP operands.
- `gdp_score`  in  16  signed ln_p from GDP.
- `gdp_score_valid`  in  1  one pulse per completed senone, in issue order.
- `score_index`  out  8  senone index of `score`.
- `score`  out  16  forwarded senone score.
- `score_valid`  out  1  `score`/`score_index` valid.
- `best_index`  out  8  index of maximum score so far.
- `best_score`  out  16  maximum score so far.
- `busy`  out  1  high outside IDLE.
- `done`  out  1  single-cycle pulse: all N_SENONES scores received.
- `overrun`  out  1  sticky: `x_valid` seen while busy.

## Operation
- States: IDLE → ISSUE → DRAIN → DONE → IDLE.
- IDLE: on `x_valid`, latch `x`, clear counters, clear `overrun`, reset best tracker to `best_score`=0x8000 and `best_index`=0; go to ISSUE.
- ISSUE: `stats_rd`=1 every cycle; component counter `c` increments and wraps N_COMPONENTS-1→0; on wrap, senone counter `s` increments. The address increments by 1 each cycle (no multiplier). After issuing (N_SENONES-1, N_COMPONENTS-1), go to DRAIN.
- A STATS_LAT-deep shift register carries (valid, c) alongside each read. On return, the GDP operand registers load stats data and `x[c]`, with `gdp_first`=(c==0) and `gdp_last`=(c==N_COMPONENTS-1).
- Return path: each `gdp_score_valid` forwards `score`, with `score_index` = receive counter, then increments the counter. Scores arriving in IDLE or DONE are dropped.
- Best tracker: strict signed `>` comparison; ties keep the lower index.
- DRAIN: wait until the receive counter equals N_SENONES, then go to DONE.
- DONE: `done`=1 for one cycle, then go to IDLE; best outputs hold until the next start.
- `x_valid` while busy: ignored and `overrun` set.

## Timing
- Reset values: all outputs 0, except `best_score`=0x8000; state IDLE.
- `x_valid` at cycle T → `busy` and first `stats_rd` at T+1 → first `gdp_en` at T+2+STATS_LAT.
- ISSUE lasts exactly N_SENONES*N_COMPONENTS cycles; `gdp_en` is a gap-free burst of the same length.
- `score_valid` is registered: it appears one cycle after `gdp_score_valid`, and `best_*` update on the same edge.
- `done` asserts the cycle after the final `score_valid`.
- Reset mid-run: immediate return to IDLE; in-flight reads and scores are discarded.

## Configuration
- `GDP_SCHED_BEST_EN` defined: best tracker compiled in, as described above.
- `GDP_SCHED_BEST_EN` undefined: no comparator; `best_index`=0 and `best_score`=0 constantly; all other behaviour unchanged.

## Structure
- Shared package `gdp_pkg`: `typedef logic signed [15:0] num`, the state enum, and the `NUM_MIN`=16'sh8000 constant.
- One sub-module, `gdp_best_tracker`: signed max with index, synchronous clear, and the `GDP_SCHED_BEST_EN` guard.

## Test plan
Bench parameters: N_COMPONENTS=3, N_SENONES=4, STATS_LAT=2.
- Reset with `reset`=0 → all outputs 0, `best_score`=0x8000, `busy`=0.
- `x_valid` at T → `stats_addr` 0..11 on T+1..T+12; `gdp_en` T+4..T+15; `gdp_first` at T+4/7/10/13; `gdp_last` at T+6/9/12/15; `gdp_x` cycles x[0],x[1],x[2].
- Scores −5, 7, 7, −100 returned → `score_index` 0..3; `best_index`=1, `best_score`=7; `done` one cycle after the 4th `score_valid`.
- All scores 0x8000 → `best_index`=0, `best_score`=0x8000.
- Second `x_valid` mid-ISSUE → `overrun`=1, address sequence unaffected; `overrun` clears on the next accepted start.
- `reset` low during DRAIN → IDLE immediately; a late `gdp_score_valid` produces no `score_valid`.
